// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, default widths and constants for hazard_stall_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        ERROR
    } state_t;

    localparam int DEF_REG_W = 5;
    localparam int DEF_CNT_W = 16;
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags the last allowed one
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic w,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;

    // Count while the wait persists; any cycle without a wait restarts from zero
    always_ff @(posedge clk) begin
        if (rst || clear || !w)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + CW'(1);
    end

    assign expired = w && (wait_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / memory-wait / branch stall and flush control; STALL_CNT_EN builds the stall counter
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [REG_W-1:0] IDEX_Rt_i,
    input  logic [REG_W-1:0] IFID_Rs_i,
    input  logic [REG_W-1:0] IFID_Rt_i,
    input  logic             Branch_taken_i,
    input  logic             Mem_req_i,
    input  logic             Mem_ready_i,
    output logic             Hazard_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFFlush_o,
    output logic             Freeze_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    state_t state, next_state;
    logic   lu, w, expired;

    assign lu = IDEX_MemRead_i && (IDEX_Rt_i != REG_W'(ZERO_REG)) &&
                (IDEX_Rt_i == IFID_Rs_i || IDEX_Rt_i == IFID_Rt_i);
    assign w  = Mem_req_i && !Mem_ready_i;

    // The counter is parked while in ERROR so it cannot wrap
    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .w       (w),
        .clear   (state == ERROR),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state and prioritised stall/flush controls
    always_comb begin
        next_state  = state;
        Hazard_o    = 1'b0;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        IFFlush_o   = 1'b0;
        Freeze_o    = 1'b0;
        case (state)
            IDLE:     next_state = w ? MEM_WAIT : IDLE;
            MEM_WAIT: next_state = !w ? IDLE : (expired ? ERROR : MEM_WAIT);
            default:  next_state = ERROR;
        endcase
        if (rst_i) begin
            next_state  = IDLE;
            Hazard_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else if (state == ERROR || w) begin
            Freeze_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else if (lu) begin
            Hazard_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else if (Branch_taken_i) begin
            IFFlush_o   = 1'b1;
        end
    end

    assign Timeout_o = (state == ERROR);

`ifdef STALL_CNT_EN
    // Saturating count of cycles in which the PC is not advanced
    always_ff @(posedge clk_i) begin
        if (rst_i)
            StallCnt_o <= '0;
        else if (!PCWrite_o && StallCnt_o != '1)
            StallCnt_o <= StallCnt_o + CNT_W'(1);
    end
`else
    assign StallCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr;
    logic [4:0]  idrt, rs, rt;
    logic        br, req, rdy;
    logic        hazard, pcw, ifidw, flush, freeze, tmo;
    logic [15:0] scnt;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    logic [5:0] q_exp[$];
    string      q_tag[$];

    // {hazard, pcwrite, ifidwrite, flush, freeze, timeout}
    localparam logic [5:0] RUN = 6'b011000;
    localparam logic [5:0] BUB = 6'b100000;
    localparam logic [5:0] RSE = 6'b100001;
    localparam logic [5:0] FLS = 6'b011100;
    localparam logic [5:0] FRZ = 6'b000010;
    localparam logic [5:0] ERR = 6'b000011;

    hazard_stall_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .IDEX_MemRead_i (mr),
        .IDEX_Rt_i      (idrt),
        .IFID_Rs_i      (rs),
        .IFID_Rt_i      (rt),
        .Branch_taken_i (br),
        .Mem_req_i      (req),
        .Mem_ready_i    (rdy),
        .Hazard_o       (hazard),
        .PCWrite_o      (pcw),
        .IFIDWrite_o    (ifidw),
        .IFFlush_o      (flush),
        .Freeze_o       (freeze),
        .Timeout_o      (tmo),
        .StallCnt_o     (scnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s,
                         input logic [4:0] t, input logic b, input logic q, input logic y);
        rst = r; mr = m; idrt = d; rs = s; rt = t; br = b; req = q; rdy = y;
    endtask

    task automatic step(input string tag, input logic [5:0] e);
        logic [5:0] got, exp_v;
        string      t;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(negedge clk);
        got   = {hazard, pcw, ifidw, flush, freeze, tmo};
        exp_v = q_exp.pop_front();
        t     = q_tag.pop_front();
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s ctrl got=%b exp=%b", t, got, exp_v);
        end
        total++;
        assert (scnt === 16'(model_cnt)) else begin
            bad++;
            $error("FAIL %s stallcnt got=%0d exp=%0d", t, scnt, model_cnt);
        end
`ifdef STALL_CNT_EN
        if (!rst && !exp_v[4]) model_cnt++;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        step("reset", BUB);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("idle", RUN);
        drive(0, 1, 8, 8, 3, 0, 0, 0);
        step("lu_rs", BUB);
        drive(0, 0, 8, 8, 3, 0, 0, 0);
        step("lu_drop", RUN);
        drive(0, 1, 9, 2, 9, 0, 0, 0);
        step("lu_rt", BUB);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step("lu_zero_reg", RUN);
        drive(0, 1, 8, 3, 4, 0, 0, 0);
        step("lu_nomatch", RUN);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        step("branch", FLS);
        drive(0, 1, 8, 8, 0, 1, 0, 0);
        step("branch_lu", BUB);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("wait4", FRZ);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("wait4_ready", RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("wait4_idle", RUN);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 14; i++) step("wait14", FRZ);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("ready_at_last", RUN);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 15; i++) step("wait_full", FRZ);
        for (int i = 0; i < 3; i++) step("timeout", ERR);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("error_sticky", ERR);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("error_noreq", ERR);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step("reset_in_error", RSE);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("after_reset", RUN);
        drive(0, 1, 8, 8, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step("wait_lu", FRZ);
        drive(0, 1, 8, 8, 0, 0, 1, 1);
        step("ready_lu", BUB);
        drive(0, 0, 8, 8, 0, 0, 0, 0);
        step("lu_clear", RUN);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
